// File: rtl/dec_change_printer.sv
// Switch monitor: prints in_value as ASCII decimal (or hex with DEC_CHANGE_PRINTER_HEX_EN)
// over an 8N1 UART, then reprints whenever the value changes and stays stable.
module dec_change_printer #(
  parameter int W             = 8,
  parameter int DIGITS        = 3,
  parameter int BAUD_DIV      = 868,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] in_value,
`ifdef DEC_CHANGE_PRINTER_HEX_EN
  input  logic         in_hex,
`endif
  output logic         out_uart_txd,
  output logic         out_busy,
  output logic         result_ready
);

  localparam int BW   = DIGITS * 4;
  localparam int SCW  = $clog2(STABLE_CYCLES + 1);
  localparam int BCW  = $clog2(BAUD_DIV);
  localparam int CCW  = $clog2(W + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic [2:0]     state_reg;
  logic [W-1:0]   sync1_reg, sync2_reg, prev_reg, copy_reg, bin_reg;
  logic [BW-1:0]  bcd_reg, bcd_adj;
  logic [CCW-1:0] conv_cnt_reg;
  logic [SCW-1:0] stab_cnt_reg, stab_inc;
  logic [BCW-1:0] baud_cnt_reg;
  logic [3:0]     bit_idx_reg;
  logic [4:0]     char_cnt_reg;
  logic           pending_reg;
  logic           hex_in, hex_mode;

  logic [4:0] first_sig, ndig, digit_pos;
  logic       found;
  logic [3:0] nib;
  logic [7:0] digit_char, tx_char;
  logic       frame_bit;

  // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                                : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // Index (from MSB) of the first printed decimal digit; value 0 keeps the last digit
  always_comb begin
    first_sig = 5'(DIGITS - 1);
    found     = 1'b0;
    for (int k = 0; k < DIGITS - 1; k++) begin
      if (!found && bcd_reg[(DIGITS-1-k)*4 +: 4] != 4'd0) begin
        first_sig = k[4:0];
        found     = 1'b1;
      end
    end
  end

  assign digit_pos = first_sig + char_cnt_reg;

  always_comb begin
    nib = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_pos == k[4:0]) nib = bcd_reg[(DIGITS-1-k)*4 +: 4];
    end
  end

`ifdef DEC_CHANGE_PRINTER_HEX_EN
  localparam int HEXD = (W + 3) / 4;
  localparam int HW   = HEXD * 4;
  logic          hex_reg;
  logic [HW-1:0] copy_pad;
  logic [3:0]    hnib;

  assign hex_in   = in_hex;
  assign hex_mode = hex_reg;
  assign copy_pad = HW'(copy_reg);

  always_comb begin
    hnib = 4'd0;
    for (int k = 0; k < HEXD; k++) begin
      if (char_cnt_reg == k[4:0]) hnib = copy_pad[(HEXD-1-k)*4 +: 4];
    end
  end

  assign ndig       = hex_mode ? 5'(HEXD) : 5'(DIGITS) - first_sig;
  assign digit_char = !hex_mode      ? 8'h30 + {4'd0, nib}
                    : (hnib < 4'd10) ? 8'h30 + {4'd0, hnib}
                    :                  8'h37 + {4'd0, hnib};
`else
  assign hex_in     = 1'b0;
  assign hex_mode   = 1'b0;
  assign ndig       = 5'(DIGITS) - first_sig;
  assign digit_char = 8'h30 + {4'd0, nib};
`endif

  assign tx_char = (char_cnt_reg < ndig)  ? digit_char
                 : (char_cnt_reg == ndig) ? 8'h0D : 8'h0A;

  always_comb begin
    case (bit_idx_reg)
      4'd0:    frame_bit = 1'b0;
      4'd9:    frame_bit = 1'b1;
      default: frame_bit = tx_char[3'(bit_idx_reg - 4'd1)];
    endcase
  end

  assign stab_inc     = stab_cnt_reg + 1'b1;
  assign out_uart_txd = (state_reg == S_EMIT) ? frame_bit : 1'b1;
  assign out_busy     = (state_reg == S_CAPTURE) || (state_reg == S_CONVERT) || (state_reg == S_EMIT);
  assign result_ready = (state_reg == S_IDLE) & ~start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      prev_reg     <= '0;
      copy_reg     <= '0;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      conv_cnt_reg <= '0;
      stab_cnt_reg <= '0;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      char_cnt_reg <= '0;
      pending_reg  <= 1'b0;
`ifdef DEC_CHANGE_PRINTER_HEX_EN
      hex_reg      <= 1'b0;
`endif
    end else begin
      sync1_reg <= in_value;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      case (state_reg)
        S_IDLE: if (start) state_reg <= S_CAPTURE;
        S_CAPTURE: begin
          copy_reg     <= sync2_reg;
          bin_reg      <= sync2_reg;
          bcd_reg      <= '0;
          conv_cnt_reg <= '0;
          stab_cnt_reg <= '0;
          baud_cnt_reg <= '0;
          bit_idx_reg  <= '0;
          char_cnt_reg <= '0;
          pending_reg  <= 1'b0;
`ifdef DEC_CHANGE_PRINTER_HEX_EN
          hex_reg      <= in_hex;
`endif
          if (start)       state_reg <= S_CAPTURE;
          else if (hex_in) state_reg <= S_EMIT;
          else             state_reg <= S_CONVERT;
        end
        S_CONVERT: begin
          if (start) begin
            state_reg <= S_CAPTURE;
          end else begin
            bcd_reg      <= BW'({bcd_adj, bin_reg[W-1]});
            bin_reg      <= bin_reg << 1;
            conv_cnt_reg <= conv_cnt_reg + 1'b1;
            if (conv_cnt_reg == CCW'(W - 1)) state_reg <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (start) pending_reg <= 1'b1;
          if (baud_cnt_reg == BCW'(BAUD_DIV - 1)) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 4'd9) begin
              bit_idx_reg <= '0;
              // A restart requested mid-line takes effect only at a frame boundary
              if (pending_reg || start)               state_reg <= S_CAPTURE;
              else if (char_cnt_reg == ndig + 5'd1)   state_reg <= S_WAIT;
              else                                    char_cnt_reg <= char_cnt_reg + 5'd1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 4'd1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        S_WAIT: begin
          if (start) begin
            state_reg <= S_CAPTURE;
          end else if (sync2_reg == copy_reg) begin
            stab_cnt_reg <= '0;
          end else if (sync2_reg != prev_reg && prev_reg != copy_reg) begin
            stab_cnt_reg <= '0;
          end else begin
            stab_cnt_reg <= stab_inc;
            if (stab_inc == SCW'(STABLE_CYCLES)) state_reg <= S_CAPTURE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
